ntt_seq_ctrl: RTL and testbench
===============================

Name: ntt_seq_ctrl

Overview:
- Sequencer for an iterative radix-2 in-place NTT/INTT over a D-entry coefficient RAM, sharing one pipelined butterfly unit (latency BF_LAT) across all stages.
- Generates RAM read/write addresses, twiddle indices and butterfly control, inserts inter-stage drain gaps, and runs the optional INTT scaling pass (multiply by D^-1 mod N).
- Replaces the fully unrolled flat transform when area matters; sits between the host start/done handshake and the RAM and butterfly datapath.

Parameters:
- N, 65537, modulus; passed through for width derivation only, DW = clog2(N).
- D, 16, transform length; must be a power of two and at least 4.
- LOGD, 4, log2(D).
- BF_LAT, 3, butterfly/scaler pipeline latency in cycles; must be at least 1.

Ports:
- clk in 1: rising-edge clock.
- rst_n in 1: asynchronous active-low reset.
- start in 1: request a transform; sampled only in IDLE.
- mode in 1: 1 = INTT, 0 = NTT; latched on an accepted start.
- rd_en out 1: RAM read strobe for butterfly or scale operand(s).
- rd_addr_a out LOGD: first operand address.
- rd_addr_b out LOGD: second operand address; 0 in SCALE.
- tw_idx out LOGD-1: twiddle ROM index.
- tw_inv out 1: selects inverse twiddles; equals the latched mode.
- scale_en out 1: butterfly unit operates as a multiply by D^-1 on operand a only.
- wr_en out 1: RAM write strobe, rd_en delayed by BF_LAT.
- wr_addr_a out LOGD: rd_addr_a delayed by BF_LAT.
- wr_addr_b out LOGD: rd_addr_b delayed by BF_LAT.
- busy out 1: high in any non-IDLE state.
- done out 1: one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, delay pipeline cleared. An operation interrupted by reset issues no further wr_en; reset does not restore RAM contents.
- FSM states: IDLE, RUN, GAP, SCALE, DRAIN, FIN.
- Start: start=1 in IDLE at edge k enters RUN, with stage s=0 and butterfly counter b=0. The first rd_en appears in cycle k+1. start while busy is ignored.
- RUN: one butterfly issued per cycle, b=0..D/2-1.
  - half=1<<s; grp=b>>s; p=b&(half-1).
  - rd_addr_a=(grp<<(s+1))+p; rd_addr_b=rd_addr_a+half; tw_idx=p<<(LOGD-1-s).
  - After b=D/2-1, go to GAP.
- GAP: exactly BF_LAT cycles with rd_en=0, so every write of stage s lands before stage s+1 reads.
  - RAM is write-first, so a write in cycle t is visible to a read in cycle t+1.
  - After the gap: if s<LOGD-1, increment s and return to RUN. Otherwise go to FIN for NTT, or to SCALE for INTT.
- SCALE: D cycles with rd_en=1, scale_en=1, rd_addr_a=i for i=0..D-1 and rd_addr_b=0. Then DRAIN for BF_LAT cycles.
- FIN: entered after the final GAP (NTT) or DRAIN (INTT). In FIN, done=1 and busy=0 for one cycle, then IDLE. A start in the FIN cycle is accepted as if in IDLE.
- Write pipeline: a BF_LAT-deep shift register carries {rd_en, rd_addr_a, rd_addr_b}. wr_en never asserts outside the BF_LAT cycles following an rd_en.
- Timing, relative to start edge k:
  - done at k+1+LOGD*(D/2+BF_LAT) for NTT.
  - For INTT, add D+BF_LAT cycles.
  - D=16, BF_LAT=3: NTT done at k+45, INTT done at k+64.
- rd_addr_a, rd_addr_b, tw_idx and scale_en are held at 0 whenever rd_en=0.
- tw_inv is constant through an operation; a mode change while busy has no effect.
- Counters wrap only through explicit reload; no address exceeds D-1.

Test Plan:
- Reset mid-RUN: assert rst_n=0 at cycle k+5 of an NTT -> all outputs 0 the same cycle. No wr_en after release, and the FSM idles until the next start.
- NTT sequence, D=16, BF_LAT=3, start at k: rd_en in cycles k+1..k+8, k+12..k+19, k+23..k+30 and k+34..k+41.
  - Stage 0: addr pairs (0,1),(2,3)...(14,15), tw_idx 0.
  - Stage 3: pairs (0,8)..(7,15), tw_idx 0..7.
  - wr_en mirrors rd_en 3 cycles later; done=1 only at k+45.
- INTT: mode=1 -> tw_inv=1 throughout. Scale reads with addresses 0..15 in k+45..k+60, scale_en=1, writes in k+48..k+63, done at k+64, busy low at k+64.
- Start ignored while busy: pulse start at k+10 and k+30 with mode toggled -> the sequence and the done cycle are unchanged from a single start.
- Back-to-back: start held high continuously -> second run's first rd_en in the cycle after done (k+46), with no overlap of wr_en from the first run.
- Hazard check with a RAM model plus a golden butterfly: random 16 coefficients mod 65537, NTT then INTT -> final RAM equals the original vector.

Source files
------------

// File: rtl/ntt_seq_ctrl.sv
// ntt_seq_ctrl: control sequencer for an iterative radix-2 in-place NTT/INTT.
// One pipelined butterfly unit is shared by every stage. This block issues one
// butterfly per cycle, waits out the pipeline between stages, and for INTT
// adds a final pass that scales each coefficient by D^-1.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, mode           start request (IDLE/FIN only), 1 = INTT
//   rd_en                 operand read strobe
//   rd_addr_a, rd_addr_b  operand addresses (b is 0 during scaling)
//   tw_idx, tw_inv        twiddle ROM index, inverse-twiddle select
//   scale_en              butterfly unit multiplies operand a by D^-1
//   wr_en, wr_addr_a/b    write-back strobe/addresses, read side delayed BF_LAT
//   busy, done            busy in any non-IDLE state, one-cycle done pulse
module ntt_seq_ctrl #(
  parameter int N      = 65537,
  parameter int D      = 16,
  parameter int LOGD   = 4,
  parameter int BF_LAT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            mode,
  output logic            rd_en,
  output logic [LOGD-1:0] rd_addr_a,
  output logic [LOGD-1:0] rd_addr_b,
  output logic [LOGD-2:0] tw_idx,
  output logic            tw_inv,
  output logic            scale_en,
  output logic            wr_en,
  output logic [LOGD-1:0] wr_addr_a,
  output logic [LOGD-1:0] wr_addr_b,
  output logic            busy,
  output logic            done
);

  if (N < 2 || D < 4 || (1 << LOGD) != D || BF_LAT < 1) begin : g_param_chk
    $error("ntt_seq_ctrl: invalid parameters");
  end

  // One counter serves as butterfly index, gap/drain timer and scale index.
  localparam int CW = $clog2(D + BF_LAT + 1);
  localparam int SW = $clog2(LOGD);
  localparam logic [CW-1:0] HALF_LAST = CW'(D/2 - 1);
  localparam logic [CW-1:0] LAT_LAST  = CW'(BF_LAT - 1);
  localparam logic [CW-1:0] D_LAST    = CW'(D - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(LOGD - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_SCALE, S_DRAIN, S_FIN} state_t;

  state_t        state;
  logic [SW-1:0] stg;
  logic [CW-1:0] cnt;

  // Butterfly b of stage s: groups of 2*half, partner half apart,
  // twiddle stride D/(2*half).
  function automatic logic [LOGD-1:0] bf_a(input int s, input int b);
    int r;
    r = ((b >> s) << (s + 1)) + (b & ((1 << s) - 1));
    return r[LOGD-1:0];
  endfunction

  function automatic logic [LOGD-1:0] bf_b(input int s, input int b);
    int r;
    r = ((b >> s) << (s + 1)) + (b & ((1 << s) - 1)) + (1 << s);
    return r[LOGD-1:0];
  endfunction

  function automatic logic [LOGD-2:0] bf_tw(input int s, input int b);
    int r;
    r = (b & ((1 << s) - 1)) << (LOGD - 1 - s);
    return r[LOGD-2:0];
  endfunction

  // tw_inv doubles as the latched mode for the whole operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      stg       <= '0;
      cnt       <= '0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_idx    <= '0;
      tw_inv    <= 1'b0;
      scale_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Address/control outputs idle at 0 unless a branch issues an op.
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_idx    <= '0;
      scale_en  <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE, S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          if (start) begin
            state     <= S_RUN;
            stg       <= '0;
            cnt       <= '0;
            tw_inv    <= mode;
            busy      <= 1'b1;
            rd_en     <= 1'b1;
            rd_addr_a <= bf_a(0, 0);
            rd_addr_b <= bf_b(0, 0);
            tw_idx    <= bf_tw(0, 0);
          end
        end
        S_RUN: begin
          if (cnt == HALF_LAST) begin
            state <= S_GAP;
            cnt   <= '0;
          end else begin
            cnt       <= cnt + 1'b1;
            rd_en     <= 1'b1;
            rd_addr_a <= bf_a(int'(stg), int'(cnt) + 1);
            rd_addr_b <= bf_b(int'(stg), int'(cnt) + 1);
            tw_idx    <= bf_tw(int'(stg), int'(cnt) + 1);
          end
        end
        // Gap lets the last write of this stage land before the next reads.
        S_GAP: begin
          if (cnt == LAT_LAST) begin
            cnt <= '0;
            if (stg != S_LAST) begin
              state     <= S_RUN;
              stg       <= stg + 1'b1;
              rd_en     <= 1'b1;
              rd_addr_a <= bf_a(int'(stg) + 1, 0);
              rd_addr_b <= bf_b(int'(stg) + 1, 0);
              tw_idx    <= bf_tw(int'(stg) + 1, 0);
            end else if (tw_inv) begin
              state    <= S_SCALE;
              rd_en    <= 1'b1;
              scale_en <= 1'b1;
            end else begin
              state <= S_FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SCALE: begin
          if (cnt == D_LAST) begin
            state <= S_DRAIN;
            cnt   <= '0;
          end else begin
            cnt       <= cnt + 1'b1;
            rd_en     <= 1'b1;
            scale_en  <= 1'b1;
            rd_addr_a <= LOGD'(cnt + 1'b1);
          end
        end
        S_DRAIN: begin
          if (cnt == LAT_LAST) begin
            state <= S_FIN;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Write-back tracks the read side through the butterfly latency.
  logic [BF_LAT-1:0]           vld_pipe;
  logic [BF_LAT-1:0][LOGD-1:0] a_pipe;
  logic [BF_LAT-1:0][LOGD-1:0] b_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      a_pipe   <= '0;
      b_pipe   <= '0;
    end else begin
      vld_pipe[0] <= rd_en;
      a_pipe[0]   <= rd_addr_a;
      b_pipe[0]   <= rd_addr_b;
      for (int i = 1; i < BF_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        a_pipe[i]   <= a_pipe[i-1];
        b_pipe[i]   <= b_pipe[i-1];
      end
    end
  end

  assign wr_en     = vld_pipe[BF_LAT-1];
  assign wr_addr_a = a_pipe[BF_LAT-1];
  assign wr_addr_b = b_pipe[BF_LAT-1];

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Bench for ntt_seq_ctrl: per-cycle output trace against a schedule built
// from the transform definition, plus a RAM/butterfly model that runs an
// NTT then INTT on random data and checks the transform results.
module tb_ntt_seq_ctrl;
  localparam int D    = 16;
  localparam int LOGD = 4;
  localparam int BL   = 3;
  localparam longint NMOD = 65537;
  localparam int MAXT = 200;

  logic       clk, rst_n, start, mode;
  logic       rd_en, tw_inv, scale_en, wr_en, busy, done;
  logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [2:0] tw_idx;

  ntt_seq_ctrl #(.N(65537), .D(D), .LOGD(LOGD), .BF_LAT(BL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .tw_idx(tw_idx), .tw_inv(tw_inv), .scale_en(scale_en),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    nchk++;
    if (o !== e) begin
      nerr++;
      $display("FAIL %s t=%0t got %h want %h", tag, $time, o, e);
    end
  endtask

  // ---------------- expected schedule ----------------
  logic       e_rd   [0:MAXT];
  logic [3:0] e_a    [0:MAXT];
  logic [3:0] e_b    [0:MAXT];
  logic [2:0] e_tw   [0:MAXT];
  logic       e_inv  [0:MAXT];
  logic       e_sc   [0:MAXT];
  logic       e_busy [0:MAXT];
  logic       e_done [0:MAXT];
  logic       cur_inv = 1'b0;

  // Cycle base+1 is the first cycle after the accepting edge.
  task automatic build(input logic m, input int base, output int dn);
    int j;
    j = base + 1;
    for (int s = 0; s < LOGD; s++) begin
      int half;
      half = 1 << s;
      for (int g = 0; g < D; g += 2 * half)
        for (int p = 0; p < half; p++) begin
          e_rd[j] = 1'b1;
          e_a[j]  = 4'(g + p);
          e_b[j]  = 4'(g + p + half);
          e_tw[j] = 3'(p * (D / (2 * half)));
          j++;
        end
      j += BL;
    end
    if (m) begin
      for (int i = 0; i < D; i++) begin
        e_rd[j] = 1'b1;
        e_sc[j] = 1'b1;
        e_a[j]  = 4'(i);
        j++;
      end
      j += BL;
    end
    for (int i = base + 1; i < j; i++) e_busy[i] = 1'b1;
    e_done[j] = 1'b1;
    for (int i = base + 1; i <= MAXT; i++) e_inv[i] = m;
    dn = j;
  endtask

  function automatic logic [24:0] obs();
    return {rd_en, rd_addr_a, rd_addr_b, tw_idx, tw_inv, scale_en,
            wr_en, wr_addr_a, wr_addr_b, busy, done};
  endfunction

  function automatic logic [24:0] expw(input int j);
    logic wr;
    logic [3:0] wa, wb;
    wr = 1'b0; wa = 4'd0; wb = 4'd0;
    if (j > BL) begin
      wr = e_rd[j-BL]; wa = e_a[j-BL]; wb = e_b[j-BL];
    end
    return {e_rd[j], e_a[j], e_b[j], e_tw[j], e_inv[j], e_sc[j],
            wr, wa, wb, e_busy[j], e_done[j]};
  endfunction

  // One operation (or two back-to-back with hold), optionally with
  // ignored start pulses and mode toggles while busy.
  task automatic do_run(input logic m1, input logic hold, input logic m2, input logic noise);
    int t1, t2, total, r;
    logic st [0:MAXT];
    logic md [0:MAXT];
    for (int j = 0; j <= MAXT; j++) begin
      e_rd[j] = 0; e_a[j] = 0; e_b[j] = 0; e_tw[j] = 0; e_inv[j] = cur_inv;
      e_sc[j] = 0; e_busy[j] = 0; e_done[j] = 0;
      st[j] = 0; md[j] = m1;
    end
    build(m1, 0, t1);
    t2 = t1;
    if (hold) build(m2, t1, t2);
    total = t2 + 4;
    if (hold) begin
      for (int j = 1; j <= t1; j++) st[j] = 1'b1;
      r = $urandom_range(1, t1);
      for (int j = r; j <= MAXT; j++) md[j] = m2;
    end
    if (noise) begin
      st[10] = 1'b1; md[10] = ~m1;
      st[30] = 1'b1; md[30] = ~m1;
      r = $urandom_range(1, t1 - 1);
      st[r] = 1'b1; md[r] = ~md[r];
    end
    mode  = m1;
    start = 1'b1;
    for (int j = 1; j <= total; j++) begin
      @(negedge clk);
      chk("trace", 32'(obs()), 32'(expw(j)));
      start = st[j];
      mode  = md[j];
    end
    cur_inv = hold ? m2 : m1;
  endtask

  // ---------------- RAM + golden butterfly ----------------
  typedef struct { logic sc; longint ra; longint rb; } bf_t;
  bf_t    bq[$];
  longint ram [0:D-1];
  longint wf, wi, dinv;

  function automatic longint modpow(input longint b, input longint e);
    longint r, bb, ee;
    r = 1; bb = b % NMOD; ee = e;
    while (ee > 0) begin
      if (ee[0]) r = r * bb % NMOD;
      bb = bb * bb % NMOD;
      ee = ee >> 1;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    bf_t    bf;
    longint a, b, t;
    if (!rst_n) begin
      bq.delete();
    end else begin
      if (wr_en) begin
        chk("wr_pending", 32'(bq.size() > 0), 32'd1);
        if (bq.size() > 0) begin
          bf = bq.pop_front();
          ram[wr_addr_a] = bf.ra;
          if (!bf.sc) ram[wr_addr_b] = bf.rb;
        end
      end
      if (rd_en) begin
        a = ram[rd_addr_a];
        b = ram[rd_addr_b];
        if (scale_en) begin
          bf.sc = 1'b1; bf.ra = a * dinv % NMOD; bf.rb = 0;
        end else begin
          t = b * modpow(tw_inv ? wi : wf, longint'(tw_idx)) % NMOD;
          bf.sc = 1'b0; bf.ra = (a + t) % NMOD; bf.rb = (a + NMOD - t) % NMOD;
        end
        bq.push_back(bf);
      end
    end
  end

  function automatic int brev(input int i);
    return int'({i[0], i[1], i[2], i[3]});
  endfunction

  task automatic roundtrip();
    longint x [0:D-1];
    longint tmp [0:D-1];
    longint xk;
    for (int i = 0; i < D; i++) x[i] = longint'($urandom_range(0, 65536));
    for (int i = 0; i < D; i++) ram[i] = x[brev(i)];
    do_run(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < D; k++) begin
      xk = 0;
      for (int n = 0; n < D; n++) xk = (xk + x[n] * modpow(wf, longint'((n * k) % D))) % NMOD;
      chk("ntt_val", 32'(ram[k]), 32'(xk));
    end
    for (int i = 0; i < D; i++) tmp[i] = ram[brev(i)];
    for (int i = 0; i < D; i++) ram[i] = tmp[i];
    do_run(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < D; i++) chk("intt_rt", 32'(ram[i]), 32'(x[i]));
  endtask

  task automatic reset_mid_run();
    mode  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'(obs()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cur_inv = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("post_rst", 32'(obs()), 32'd0);
    end
  endtask

  initial begin
    wf   = modpow(3, (NMOD - 1) / D);
    wi   = modpow(wf, D - 1);
    dinv = modpow(D, NMOD - 2);
    for (int i = 0; i < D; i++) ram[i] = 0;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", 32'(obs()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle", 32'(obs()), 32'd0);

    do_run(1'b0, 1'b0, 1'b0, 1'b1);
    do_run(1'b1, 1'b0, 1'b1, 1'b1);
    do_run(1'b0, 1'b1, 1'b1, 1'b0);
    reset_mid_run();
    roundtrip();
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_run(1'($urandom_range(0, 1)), 1'(i % 2), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
